posit_batch_engine: RTL
=======================

POSIT_BATCH_ENGINE -- requirements
Module: posit_batch_engine

Interface
REQ-001 SHALL have parameter RD_LAT, default 1, meaning operand-memory read latency in cycles; legal values are 1 and 2.
REQ-002 SHALL have parameter MAX_PAIRS, default 512, meaning the pair-count clamp (4096 bytes / 8).
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit: level from the start PIO.
REQ-006 SHALL have port soft_reset, input, 1 bit: level from the reset PIO, synchronous active-high clear.
REQ-007 SHALL have port pair_count, input, 32 bits: requested operand pairs (num1 PIO).
REQ-008 SHALL have port completed, output, 1 bit: batch done, to the completed PIO.
REQ-009 SHALL have port status_out, output, 32 bits: status word, to the result PIO.
REQ-010 SHALL have ports opm_address (output, 12), opm_chipselect (output, 1), opm_clken (output, 1), opm_write (output, 1), opm_writedata (output, 8) and opm_readdata (input, 8): the operand memory s2 port.
REQ-011 SHALL have ports rsm_address (output, 12), rsm_chipselect (output, 1), rsm_clken (output, 1), rsm_write (output, 1), rsm_writedata (output, 8) and rsm_readdata (input, 8, unused): the result memory s2 port.
REQ-012 SHALL have ports op_valid (output, 1), op_ready (input, 1), op_a (output, 32) and op_b (output, 32): issue to the posit arithmetic unit.
REQ-013 SHALL have ports res_valid (input, 1) and res_data (input, 32): result from the posit arithmetic unit, which is always accepted.

Function
REQ-014 SHALL use FSM states IDLE, LOAD, ISSUE, WAIT, STORE, DONE.
REQ-015 SHALL start a batch on a rising edge of start, registered against its previous value, when in IDLE or DONE; start edges in any other state are ignored.
REQ-016 SHALL latch N = min(pair_count, MAX_PAIRS) at start; N=0 goes directly to DONE with status 0.
REQ-017 SHALL read operand pair i in LOAD from bytes 8i..8i+7: op_a from 8i..8i+3 and op_b from 8i+4..8i+7, little-endian.
REQ-018 SHALL issue the 8 LOAD reads on consecutive cycles with chipselect=1 and write=0, capture each byte RD_LAT cycles after its address, and leave LOAD when the 8th byte is captured (8+RD_LAT cycles).
REQ-019 SHALL hold op_valid with stable op_a/op_b in ISSUE until op_valid&&op_ready, then go to WAIT; at most one operation is in flight.
REQ-020 SHALL capture res_data in WAIT on res_valid and go to STORE; res_valid outside WAIT is ignored.
REQ-021 SHALL write the result in STORE to rsm bytes 4i..4i+3, little-endian, on 4 consecutive cycles with chipselect=1 and write=1.
REQ-022 SHALL, after STORE, increment i and go to LOAD if i<N, otherwise to DONE.
REQ-023 SHALL assert completed in DONE and hold it until the next accepted start edge or a soft_reset.
REQ-024 SHALL drive chipselect and write low on both memory ports whenever no access is in progress.
REQ-025 SHALL make status_out[9:0] equal the count of pairs stored so far, with the upper bits 0.

Reset
REQ-026 SHALL, on reset_n low, go to IDLE with every output 0 (clken included), i=0 and the start-edge register 0.
REQ-027 SHALL drive opm_clken and rsm_clken to 1 from the first clock after reset release.
REQ-028 SHALL, on soft_reset high, enter IDLE on the next edge and clear completed, status_out, i, op_valid, chipselect and write; clken is unaffected.
REQ-029 SHALL let soft_reset abort a batch in any state, including mid-STORE (a partial word is permitted), and take priority over a simultaneous start edge.

Configuration
REQ-030 SHALL, with POSIT_BATCH_CHECKSUM_EN defined, make status_out the running XOR of all stored results: cleared at start and on any reset, valid in DONE.
REQ-031 SHALL, without POSIT_BATCH_CHECKSUM_EN, behave per REQ-025 and synthesize no checksum logic.

Structure
REQ-032 SHALL place the state enum, MAX_PAIRS, PAIR_BYTES=8 and RES_BYTES=4 in the shared package posit_batch_pkg.
REQ-033 SHALL implement byte capture and word assembly (RD_LAT alignment, little-endian packing) as the single sub-module pb_word_assembler.

Verification
REQ-034 SHALL cover: pair_count=1, op memory bytes 00 00 00 40 00 00 00 40, stub returns 0x50000000 with 3-cycle latency -> rsm bytes 0..3 = 00 00 00 50, completed=1, status_out=1.
REQ-035 SHALL cover: pair_count=0 with a start edge -> completed the next cycle, no chipselect on either port, status_out=0.
REQ-036 SHALL cover: pair_count=1000 -> exactly 512 pairs processed, last write at rsm address 2047, status_out=512.
REQ-037 SHALL cover: op_ready held low for 20 cycles -> op_valid, op_a and op_b stable throughout, a single handshake.
REQ-038 SHALL cover: soft_reset asserted during the 2nd STORE byte -> IDLE next cycle, chipselect=0, completed=0; a new start runs cleanly.
REQ-039 SHALL cover: with the checksum macro, 3 pairs with results 0x1, 0x2, 0x4 -> status_out=0x7; without the macro -> status_out=3.

Source files
------------

// File: rtl/posit_batch_pkg.sv
// Shared types and sizing constants for the posit batch engine.
package posit_batch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    WAIT,
    STORE,
    DONE
  } state_e;

  localparam int MAX_PAIRS  = 512;
  localparam int PAIR_BYTES = 8;
  localparam int RES_BYTES  = 4;

endpackage

// File: rtl/pb_word_assembler.sv
// Aligns operand-memory bytes to their read latency and packs them little-endian
// into the op_a / op_b words of one operand pair.
module pb_word_assembler #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr_i,
  input  logic        rd_issue_i,
  input  logic [7:0]  rd_data_i,
  output logic        last_o,
  output logic [31:0] word_a_o,
  output logic [31:0] word_b_o
);
  import posit_batch_pkg::*;

  logic [RD_LAT-1:0]              vld_q;
  logic [2:0]                     cnt_q;
  logic [PAIR_BYTES-1:0][7:0]     bytes_q;
  logic                           cap;

  assign cap    = vld_q[RD_LAT-1];
  assign last_o = cap && (cnt_q == 3'(PAIR_BYTES - 1));

  // vld_q tracks which cycles carry a byte that was addressed RD_LAT cycles ago
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q   <= '0;
      cnt_q   <= '0;
      bytes_q <= '0;
    end else if (clr_i) begin
      vld_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q[0] <= rd_issue_i;
      for (int k = RD_LAT - 1; k > 0; k--) vld_q[k] <= vld_q[k-1];
      if (cap) begin
        bytes_q[cnt_q] <= rd_data_i;
        cnt_q          <= cnt_q + 3'd1;
      end
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_pack
    assign word_a_o[8*gi +: 8] = bytes_q[gi];
    assign word_b_o[8*gi +: 8] = bytes_q[gi+4];
  end

endmodule

// File: rtl/posit_batch_engine.sv
// Batch sequencer: loads operand pairs, issues them to a posit unit, stores results.
// Define POSIT_BATCH_CHECKSUM_EN to report an XOR checksum of results in status_out.
module posit_batch_engine #(
  parameter int RD_LAT    = 1,
  parameter int MAX_PAIRS = posit_batch_pkg::MAX_PAIRS
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        soft_reset,
  input  logic [31:0] pair_count,
  output logic        completed,
  output logic [31:0] status_out,
  output logic [11:0] opm_address,
  output logic        opm_chipselect,
  output logic        opm_clken,
  output logic        opm_write,
  output logic [7:0]  opm_writedata,
  input  logic [7:0]  opm_readdata,
  output logic [11:0] rsm_address,
  output logic        rsm_chipselect,
  output logic        rsm_clken,
  output logic        rsm_write,
  output logic [7:0]  rsm_writedata,
  input  logic [7:0]  rsm_readdata,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  input  logic        res_valid,
  input  logic [31:0] res_data
);
  import posit_batch_pkg::*;

  localparam int CW = $clog2(MAX_PAIRS + 1);

  state_e         state_q, state_d;
  logic           start_q;
  logic [CW-1:0]  n_q, n_d, i_q, i_d, n_start;
  logic [3:0]     cnt_q, cnt_d;
  logic [31:0]    res_q, res_d;
  logic           clken_q;
  logic           accept, last_byte, store_last;
  logic           unused_rsm;

  assign unused_rsm = ^rsm_readdata;
  assign accept     = (state_q == IDLE || state_q == DONE) && start && !start_q;
  assign store_last = (state_q == STORE) && (cnt_q == 4'(RES_BYTES - 1));
  assign n_start    = (pair_count > 32'(MAX_PAIRS)) ? CW'(MAX_PAIRS) : pair_count[CW-1:0];

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    i_d     = i_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          n_d     = n_start;
          i_d     = '0;
          cnt_d   = '0;
          state_d = (n_start == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (cnt_q < 4'(PAIR_BYTES)) cnt_d = cnt_q + 4'd1;
        if (last_byte) begin
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: if (op_ready) state_d = WAIT;
      WAIT: begin
        if (res_valid) begin
          res_d   = res_data;
          state_d = STORE;
        end
      end
      STORE: begin
        cnt_d = cnt_q + 4'd1;
        if (store_last) begin
          cnt_d   = '0;
          i_d     = i_q + CW'(1);
          state_d = ((i_q + CW'(1)) < n_q) ? LOAD : DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    // soft_reset overrides everything, including a start edge in the same cycle
    if (soft_reset) begin
      state_d = IDLE;
      i_d     = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      n_q     <= '0;
      i_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      clken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      n_q     <= n_d;
      i_q     <= i_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      clken_q <= 1'b1;
    end
  end

  pb_word_assembler #(.RD_LAT(RD_LAT)) u_asm (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr_i      (soft_reset),
    .rd_issue_i (opm_chipselect),
    .rd_data_i  (opm_readdata),
    .last_o     (last_byte),
    .word_a_o   (op_a),
    .word_b_o   (op_b)
  );

  assign opm_chipselect = (state_q == LOAD) && (cnt_q < 4'(PAIR_BYTES));
  assign opm_write      = 1'b0;
  assign opm_writedata  = 8'h00;
  assign opm_address    = 12'({i_q, 3'b000}) + 12'(cnt_q);
  assign opm_clken      = clken_q;

  assign rsm_chipselect = (state_q == STORE);
  assign rsm_write      = (state_q == STORE);
  assign rsm_address    = 12'({i_q, 2'b00}) + 12'(cnt_q);
  assign rsm_writedata  = res_q[{cnt_q[1:0], 3'b000} +: 8];
  assign rsm_clken      = clken_q;

  assign op_valid  = (state_q == ISSUE);
  assign completed = (state_q == DONE);

`ifdef POSIT_BATCH_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (accept)     csum_d = '0;
    if (store_last) csum_d = csum_q ^ res_q;
    if (soft_reset) csum_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) csum_q <= '0;
    else          csum_q <= csum_d;
  end

  assign status_out = csum_q;
`else
  assign status_out = 32'(i_q);
`endif

endmodule
